// File: rtl/rr_grant_ctrl_pkg.sv
// arb_pkg: shared FSM state type and round-robin pick function for rr_grant_ctrl
package arb_pkg;
  typedef enum logic {IDLE, GRANT} state_t;
  localparam int MAX_N = 32;
  typedef struct packed {
    logic        vld;
    logic [31:0] idx;
  } pick_t;
  // Scans offsets N..1 from last so the smallest offset (closest after last) wins.
  function automatic pick_t rr_pick(input logic [MAX_N-1:0] req, input int n, input int last,
                                    input logic exclude_en, input int exclude_idx);
    pick_t p;
    int k;
    p = '0;
    for (int i = MAX_N; i >= 1; i--) begin
      if (i <= n) begin
        k = (last + i >= n) ? last + i - n : last + i;
        if (req[k] && !(exclude_en && k == exclude_idx)) begin
          p.vld = 1'b1;
          p.idx = k;
        end
      end
    end
    return p;
  endfunction
endpackage

// File: rtl/rr_grant_ctrl_pick.sv
// rr_pick_n: combinational round-robin picker starting after last, optional exclusion
module rr_pick_n import arb_pkg::*; #(
  parameter int N = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  input  logic          exclude_en,
  input  logic [IW-1:0] exclude_idx,
  output logic          vld,
  output logic [IW-1:0] idx
);
  pick_t p;
  always_comb begin
    p = rr_pick(MAX_N'(req), N, int'(last), exclude_en, int'(exclude_idx));
    vld = p.vld;
    idx = p.idx[IW-1:0];
  end
endmodule

// File: rtl/rr_grant_ctrl.sv
// rr_grant_ctrl: round-robin grant controller with per-owner hold limit and preempt pulse
module rr_grant_ctrl import arb_pkg::*; #(
  parameter int N = 4,
  parameter int MAX_HOLD = 8,
  localparam int IW = $clog2(N),
  localparam int HW = $clog2(MAX_HOLD + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  req,
  output logic [N-1:0]  gnt,
  output logic          gnt_vld,
  output logic [IW-1:0] gnt_id,
  output logic          preempt
);
  if (N < 2 || N > MAX_N || MAX_HOLD < 1) begin : g_bad_param
    $error("rr_grant_ctrl: need 2 <= N <= MAX_N and MAX_HOLD >= 1");
  end
  state_t state, nxt_state;
  logic [IW-1:0] last, nxt_last, pk_idx;
  logic [HW-1:0] hold_cnt, nxt_hold;
  logic nxt_pre, pk_vld, at_limit, own_req;
  assign own_req = req[last];
  assign at_limit = state == GRANT && hold_cnt == HW'(MAX_HOLD);
  rr_pick_n #(.N(N)) u_pick (
    .req(req),
    .last(last),
    .exclude_en(at_limit),
    .exclude_idx(last),
    .vld(pk_vld),
    .idx(pk_idx)
  );
  // A lone owner at the limit finds no other pick and is re-granted with a fresh count.
  always_comb begin
    nxt_state = state;
    nxt_last = last;
    nxt_hold = hold_cnt;
    nxt_pre = 1'b0;
    if (state == IDLE || !own_req) begin
      nxt_state = pk_vld ? GRANT : IDLE;
      nxt_last = pk_vld ? pk_idx : last;
      nxt_hold = pk_vld ? HW'(1) : '0;
    end else if (at_limit) begin
      nxt_pre = 1'b1;
      nxt_last = pk_vld ? pk_idx : last;
      nxt_hold = HW'(1);
    end else begin
      nxt_hold = hold_cnt + HW'(1);
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      last <= IW'(N - 1);
      hold_cnt <= '0;
      gnt <= '0;
      gnt_id <= '0;
      preempt <= 1'b0;
    end else begin
      state <= nxt_state;
      last <= nxt_last;
      hold_cnt <= nxt_hold;
      gnt <= nxt_state == GRANT ? N'(1) << nxt_last : '0;
      gnt_id <= nxt_state == GRANT ? nxt_last : '0;
      preempt <= nxt_pre;
    end
  end
  assign gnt_vld = |gnt;
endmodule

// File: doc/rr_grant_ctrl.md
# rr_grant_ctrl

Round-robin arbiter/controller that shares one resource among N requesters with bounded grant latency and a maximum hold time per owner. Sits in front of the shared datapath and produces a registered one-hot grant. Its grant-latency guarantee is the property the concurrent-assertion benches check: req |-> ##[1:2] gnt when the resource is free.

## Interface
- N, default 4: number of requesters; must be ≥ 2.
- MAX_HOLD, default 8: maximum consecutive cycles one owner may hold the grant; must be ≥ 1.

- clk  input  1  single clock; all state updates on posedge.
- rst_n  input  1  reset, asynchronous, active-low.
- req  input  N  level requests; bit i held high while requester i wants or uses the resource.
- gnt  output  N  registered one-hot grant, or all-zero.
- gnt_vld  output  1  OR of gnt.
- gnt_id  output  $clog2(N)  index of the current owner; 0 when gnt_vld = 0.
- preempt  output  1  one-cycle pulse when an owner loses the grant by reaching MAX_HOLD.

## Operation
- Two states:
  - IDLE: no grant.
  - GRANT: one owner holds the grant.
- Registered state:
  - last: index of the most recent owner.
  - hold_cnt: cycles held so far; width $clog2(MAX_HOLD+1).
- IDLE → GRANT: on any req bit high at a posedge.
  - Pick the first set bit searching from last+1 upward, modulo N.
  - Set gnt, gnt_id and last to the picked index; hold_cnt = 1.
- In GRANT, at each posedge:
  - Release (req[owner] = 0):
    - If another req is pending, hand off directly to the round-robin pick; no idle cycle.
    - Otherwise go to IDLE.
  - Hold limit (req[owner] = 1 and hold_cnt == MAX_HOLD):
    - Pulse preempt for one cycle.
    - Pick the next owner excluding the current one.
    - If the current owner is the only requester, re-grant it and set hold_cnt = 1; preempt still pulses.
  - Otherwise keep the owner and increment hold_cnt.
- Release and hold limit in the same cycle: treat as release; no preempt.
- Requests appearing while the resource is owned wait for release or preemption.
- Worst-case wait for any requester: (N-1)*MAX_HOLD + 1 cycles.
- A req pulse shorter than one clock between posedges is not seen.

## Timing
- Reset (asynchronous, rst_n low): gnt = 0, gnt_vld = 0, gnt_id = 0, preempt = 0, state = IDLE, hold_cnt = 0, last = N-1 (so index 0 has first priority).
- Deassertion of rst_n is synchronized externally; the first evaluation is at the next posedge.
- Latency, req rise → gnt when IDLE: 1 posedge. Req set before edge k gives gnt high after edge k.
- Handoff latency on release: the new owner's gnt rises at the same edge the old owner's gnt falls.
- After a release, gnt falls 1 edge after req[owner] falls.
- preempt coincides with the edge that changes ownership.
- Reset asserted mid-grant clears outputs immediately, without waiting for clk. No partial state survives.

## Structure
- Shared package arb_pkg:
  - state typedef (IDLE, GRANT).
  - Function rr_pick(req, last, exclude_en, exclude_idx), returning a valid flag and an index.
- One natural sub-module: rr_pick_n, a combinational round-robin picker parameterized by N.
  - The controller holds the FSM, hold_cnt, last and the output registers.
- Elaboration-time checks: N ≥ 2, MAX_HOLD ≥ 1.

## Test plan
- Reset/idle: rst_n low for 2 cycles with req = 4'b1111 → gnt = 0, gnt_id = 0, preempt = 0. First edge after release: gnt = 4'b0001.
- Latency: req = 4'b0100 rises before edge 3 → gnt = 4'b0100 after edge 3. Assertion req |-> ##[1:2] gnt_vld passes.
- Round-robin handoff: req = 4'b1011 held. Each owner drops its req after 2 granted cycles and raises it again 1 cycle later → grant order 0,1,3,0 with no idle gap.
- Preempt (MAX_HOLD = 8): req = 4'b0011 held constantly → owner 0 holds 8 cycles, preempt pulses, owner 1 holds 8 cycles, then owner 0 again.
- Sole requester at limit: req = 4'b0100 only → gnt stays 4'b0100 continuously, preempt pulses every 8 cycles. Release on cycle 8 instead → no preempt, IDLE.
- Async reset mid-grant: drop rst_n between edges while gnt = 4'b0010 → gnt = 0 before the next posedge. After release, priority restarts at index 0.
